// File: rtl/dmem_pkg.sv
// Shared constants, RISC-V funct3 load/store size encodings and legality
// helpers for the byte-enabled data memory.
package dmem_pkg;

  localparam int DATA_W = 32;
  localparam int LANES  = DATA_W / 8;

  // funct3 encodings shared by loads and stores (stores use only B/H/W).
  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  // A store is legal for SB/SH/SW with natural alignment.
  function automatic logic store_legal(input logic [2:0] size, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (size)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // A load is legal for LB/LH/LW/LBU/LHU with natural alignment.
  function automatic logic load_legal(input logic [2:0] size, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (size)
      F3_B, F3_BU: ok = 1'b1;
      F3_H, F3_HU: ok = ~off[0];
      F3_W:        ok = (off == 2'b00);
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load alignment: picks the addressed byte/halfword out of a memory word and
// sign- or zero-extends it according to the load funct3.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [DATA_W-1:0] i_word,
  input  logic [2:0]        i_size,
  input  logic [1:0]        i_off,
  output logic [DATA_W-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_off, 3'b000} +: 8];
  assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

  // Extend the selected lane; illegal sizes produce zero.
  // NOTE: o_data gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    o_data = '0;
    case (i_size)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_W:    o_data = i_word;
      F3_BU:   o_data = {24'h0, w_byte};
      F3_HU:   o_data = {16'h0, w_half};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_be.sv
// Byte-enabled single-clock data memory with one write port and one
// registered read port. Reads are write-first against a same-cycle store to
// the same word; illegal or misaligned accesses raise one-cycle error pulses.
module dmem_be
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = dmem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re,
  input  logic [ADDR_W-1:0] r_addr,
  input  logic [2:0]        r_size,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              r_err,
  input  logic              we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [2:0]        w_size,
  input  logic [DATA_W-1:0] wdata,
  output logic              w_err
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 2 ** IDX_W;

  // The lane logic is written for 4 byte lanes; refuse other widths.
  if (DATA_W != 32) begin : g_bad_data_w
    $error("dmem_be: DATA_W must be 32");
  end

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;
  logic              r_rerr;
  logic              r_werr;

  logic [IDX_W-1:0]  w_widx;
  logic [1:0]        w_woff;
  logic              w_wlegal;
  logic              w_wdo;
  logic [LANES-1:0]  w_wmask;
  logic [DATA_W-1:0] w_wlanes;

  logic [IDX_W-1:0]  w_ridx;
  logic [1:0]        w_roff;
  logic              w_rlegal;
  logic              w_fwd;
  logic [DATA_W-1:0] w_rword;
  logic [DATA_W-1:0] w_rmerged;
  logic [DATA_W-1:0] w_rext;

  assign w_widx   = w_addr[ADDR_W-1:2];
  assign w_woff   = w_addr[1:0];
  assign w_wlegal = store_legal(w_size, w_woff);
  // Writes are suppressed while reset is held, including the edge at which
  // reset is first seen low.
  assign w_wdo    = rst_n && we && w_wlegal;

  assign w_ridx   = r_addr[ADDR_W-1:2];
  assign w_roff   = r_addr[1:0];
  assign w_rlegal = load_legal(r_size, w_roff);

  // Build the byte-lane enable and replicate store data onto every lane so
  // the enabled lane always finds its bytes in place.
  always_comb begin
    w_wmask  = '0;
    w_wlanes = wdata;
    case (w_size)
      F3_B: begin
        w_wmask  = 4'b0001 << w_woff;
        w_wlanes = {4{wdata[7:0]}};
      end
      F3_H: begin
        w_wmask  = w_woff[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{wdata[15:0]}};
      end
      F3_W: begin
        w_wmask  = 4'b1111;
        w_wlanes = wdata;
      end
      default: begin
        w_wmask  = '0;
        w_wlanes = wdata;
      end
    endcase
  end

  // Memory array write: only enabled lanes of a legal store change.
  // NOTE: the array has no reset so it maps onto RAM and keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (w_wdo) begin
      for (int i = 0; i < LANES; i++) begin
        if (w_wmask[i]) begin
          r_mem[w_widx][8*i +: 8] <= w_wlanes[8*i +: 8];
        end
      end
    end
  end

  assign w_rword = r_mem[w_ridx];
  assign w_fwd   = w_wdo && (w_widx == w_ridx);

  // Write-first merge: lanes being written this edge come from the store data.
  always_comb begin
    w_rmerged = w_rword;
    if (w_fwd) begin
      for (int i = 0; i < LANES; i++) begin
        if (w_wmask[i]) begin
          w_rmerged[8*i +: 8] = w_wlanes[8*i +: 8];
        end
      end
    end
  end

  dmem_load_align u_align (
    .i_word (w_rmerged),
    .i_size (r_size),
    .i_off  (w_roff),
    .o_data (w_rext)
  );

  // Registered read result and error pulses; rdata holds when idle.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_rerr   <= 1'b0;
      r_werr   <= 1'b0;
    end else begin
      r_rvalid <= re && w_rlegal;
      r_rerr   <= re && !w_rlegal;
      r_werr   <= we && !w_wlegal;
      if (re) begin
        r_rdata <= w_rlegal ? w_rext : '0;
      end
    end
  end

  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign r_err  = r_rerr;
  assign w_err  = r_werr;

endmodule

// File: doc/dmem_be.md
DMEM_BE -- requirements
Module: dmem_be

Interface
REQ-001 Parameter ADDR_W, default 7, byte-address width; DEPTH = 2**(ADDR_W-2) words.
REQ-002 Parameter DATA_W, fixed 32, word width; any other value SHALL fail elaboration.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 re  input  1  read request, sampled on rising clk.
REQ-006 r_addr  input  ADDR_W  read byte address.
REQ-007 r_size  input  3  load type, RISC-V funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-008 rdata  output  32  registered, extended load result.
REQ-009 rvalid  output  1  one-cycle pulse; rdata valid.
REQ-010 r_err  output  1  one-cycle pulse; illegal or misaligned read.
REQ-011 we  input  1  write request, sampled on rising clk.
REQ-012 w_addr  input  ADDR_W  write byte address.
REQ-013 w_size  input  3  store type, funct3: 000 SB, 001 SH, 010 SW.
REQ-014 wdata  input  32  store data, low-aligned (SB uses [7:0], SH uses [15:0]).
REQ-015 w_err  output  1  one-cycle pulse; illegal or misaligned write.

Function
REQ-016 Word index SHALL be addr[ADDR_W-1:2]; byte offset SHALL be addr[1:0].
REQ-017 Write legal when w_size in {000,001,010} and aligned (SH: w_addr[0]=0; SW: w_addr[1:0]=0).
REQ-018 Legal write SHALL update only the addressed byte lanes at that edge; other lanes unchanged.
REQ-019 Illegal/misaligned write SHALL leave memory unchanged and assert w_err for the following cycle.
REQ-020 Read legal when r_size in {000,001,010,100,101} and aligned (LH/LHU: r_addr[0]=0; LW: r_addr[1:0]=0).
REQ-021 Read latency SHALL be exactly one cycle: re at edge N -> rvalid/rdata valid after edge N, until edge N+1.
REQ-022 LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; LW SHALL return the full word.
REQ-023 Illegal/misaligned read SHALL assert r_err (not rvalid) for one cycle and drive rdata = 0.
REQ-024 rdata SHALL hold its last value when re=0; rvalid and r_err SHALL be 0 that cycle.
REQ-025 Back-to-back reads every cycle SHALL be supported with no bubbles.
REQ-026 Read and write in the same cycle to different words SHALL both complete independently.
REQ-027 Read and write in the same cycle to the same word SHALL be write-first: written lanes return new data, unwritten lanes old data.
REQ-028 A write flagged illegal SHALL NOT be forwarded to a concurrent read.
REQ-029 Index arithmetic SHALL wrap naturally within DEPTH; no out-of-range condition exists.

Reset
REQ-030 rst_n low SHALL immediately force rdata = 0, rvalid = 0, r_err = 0, w_err = 0.
REQ-031 Memory array contents SHALL NOT be reset; they are preserved across reset.
REQ-032 re/we sampled while rst_n low SHALL be ignored; a write in the edge coincident with reset assertion SHALL NOT occur.
REQ-033 First request SHALL be accepted on the first rising clk after rst_n deasserts.

Structure
REQ-034 Package dmem_pkg SHALL hold the funct3 size encodings and the DATA_W constant.
REQ-035 Combinational sub-module dmem_load_align SHALL perform lane select and sign/zero extension; write lane-mask generation stays in dmem_be.

Verification
REQ-036 SW 0x00000010 @0x04, then LW @0x04 -> rvalid one cycle later, rdata = 0x00000010.
REQ-037 SW 0x11223344 @0x08; SB 0xAA @0x09; LW @0x08 -> 0x1122AA44; LB @0x09 -> 0xFFFFFFAA; LBU @0x09 -> 0x000000AA.
REQ-038 SH @0x05 or LW @0x02 -> w_err/r_err pulse one cycle, memory unchanged, rvalid = 0, rdata = 0.
REQ-039 Same cycle: SH 0xBEEF @0x0C (word 0xCAFE0000 before) and LW @0x0C -> rdata = 0xCAFEBEEF; different-word read returns old value.
REQ-040 Reads every cycle @0x00,0x04,0x08 -> three consecutive rvalid cycles with matching data; r_size=011 -> r_err.
REQ-041 Assert rst_n low mid-read -> rvalid/rdata drop to 0 immediately; after release LW @0x08 still returns 0x1122AA44.
